id_bypass_stage: RTL and testbench

ID_BYPASS_STAGE -- requirements
Module: id_bypass_stage

---
 rtl/id_bypass_stage.sv | 155 +++++++++++++++
 tb/tb_id_bypass_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_bypass_stage.sv
// ---------------------------------------------------------------------------
// id_bypass_stage
//
// Instruction-decode pipeline register with operand bypassing.
// Holds the instruction delivered by IF, reads its source register numbers
// out of the held instruction word, and selects each operand from the
// youngest forwarding source that writes that register (or from the
// register file when no source matches). If the chosen source cannot supply
// its result yet, the stage stalls and counts the stalled cycles.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   if_valid_in               IF presents a valid instruction
//   if_PC_in/NNPC/Instruct    IF payload
//   id_allowin_out            ID accepts a new instruction this cycle
//   rd1_en_in, rd2_en_in      held instruction actually reads rs / rt
//   id_RR1_out, id_RR2_out    register-file read numbers (rs, rt)
//   rf_RD1_in, rf_RD2_in      register-file read data
//   fwd_valid_in/rdy_in       per-source: writes a register / result ready
//   fwd_wnum_in, fwd_data_in  per-source destination and data, packed
//   exe_allowin_in            EXE can accept
//   flush_in                  kill the ID contents and the incoming instr
//   id_valid_out              ID hands a valid instruction to EXE
//   id_PC/NNPC/Instruct_out   held payload
//   id_RD1_out, id_RD2_out    bypassed operands
//   id_stall_cnt_out          saturating hazard-stall cycle count
// ---------------------------------------------------------------------------
module id_bypass_stage #(
    parameter int          DATA_W   = 32,
    parameter int          NUM_FWD  = 3,
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_valid_in,
    output logic                      id_allowin_out,
    input  logic [31:0]               if_PC_in,
    input  logic [31:0]               if_NNPC_in,
    input  logic [31:0]               if_Instruct_in,
    input  logic                      rd1_en_in,
    input  logic                      rd2_en_in,
    output logic [4:0]                id_RR1_out,
    output logic [4:0]                id_RR2_out,
    input  logic [DATA_W-1:0]         rf_RD1_in,
    input  logic [DATA_W-1:0]         rf_RD2_in,
    input  logic [NUM_FWD-1:0]        fwd_valid_in,
    input  logic [NUM_FWD-1:0]        fwd_rdy_in,
    input  logic [5*NUM_FWD-1:0]      fwd_wnum_in,
    input  logic [DATA_W*NUM_FWD-1:0] fwd_data_in,
    input  logic                      exe_allowin_in,
    input  logic                      flush_in,
    output logic                      id_valid_out,
    output logic [31:0]               id_PC_out,
    output logic [31:0]               id_NNPC_out,
    output logic [31:0]               id_Instruct_out,
    output logic [DATA_W-1:0]         id_RD1_out,
    output logic [DATA_W-1:0]         id_RD2_out,
    output logic [CNT_W-1:0]          id_stall_cnt_out
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              vld_p0;
    logic [31:0]       pc_p0;
    logic [31:0]       nnpc_p0;
    logic [31:0]       instr_p0;
    logic [CNT_W-1:0]  stall_cnt_p0;

    logic [4:0]        rr1;
    logic [4:0]        rr2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              hit1;
    logic              hit2;
    logic              rdy1;
    logic              rdy2;
    logic              hazard;
    logic              ready;
    logic              accept;

    // ---- stage p0: operand select on the held instruction ----
    assign rr1 = instr_p0[25:21];
    assign rr2 = instr_p0[20:16];

    // Scan from oldest to youngest so the lowest-index match is the one
    // left standing; its ready bit alone decides the hazard.
    always_comb begin
        rd1  = rf_RD1_in;
        rd2  = rf_RD2_in;
        hit1 = 1'b0;
        hit2 = 1'b0;
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid_in[i] && rd1_en_in && (rr1 != 5'd0) &&
                (fwd_wnum_in[i*5 +: 5] == rr1)) begin
                rd1  = fwd_data_in[i*DATA_W +: DATA_W];
                hit1 = 1'b1;
                rdy1 = fwd_rdy_in[i];
            end
            if (fwd_valid_in[i] && rd2_en_in && (rr2 != 5'd0) &&
                (fwd_wnum_in[i*5 +: 5] == rr2)) begin
                rd2  = fwd_data_in[i*DATA_W +: DATA_W];
                hit2 = 1'b1;
                rdy2 = fwd_rdy_in[i];
            end
        end
        // $zero always reads as zero, whatever the sources claim
        if (rr1 == 5'd0) rd1 = '0;
        if (rr2 == 5'd0) rd2 = '0;
    end

    assign hazard = vld_p0 && ((hit1 && !rdy1) || (hit2 && !rdy2));
    assign ready  = !hazard;

    assign id_allowin_out = !vld_p0 || (ready && exe_allowin_in) || flush_in;
    assign id_valid_out   = vld_p0 && ready && !flush_in;
    assign accept         = id_allowin_out && if_valid_in && !flush_in;

    // ---- stage boundary: IF -> ID registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0       <= 1'b0;
            pc_p0        <= RESET_PC;
            nnpc_p0      <= RESET_PC + 32'd8;
            instr_p0     <= 32'd0;
            stall_cnt_p0 <= '0;
        end else begin
            if (id_allowin_out) begin
                vld_p0 <= if_valid_in && !flush_in;
            end
            if (accept) begin
                pc_p0    <= if_PC_in;
                nnpc_p0  <= if_NNPC_in;
                instr_p0 <= if_Instruct_in;
            end
            if (hazard && !flush_in) begin
                stall_cnt_p0 <= sat_inc(stall_cnt_p0);
            end
        end
    end

    assign id_RR1_out       = rr1;
    assign id_RR2_out       = rr2;
    assign id_RD1_out       = rd1;
    assign id_RD2_out       = rd2;
    assign id_PC_out        = pc_p0;
    assign id_NNPC_out      = nnpc_p0;
    assign id_Instruct_out  = instr_p0;
    assign id_stall_cnt_out = stall_cnt_p0;

endmodule

// File: tb/tb_id_bypass_stage.sv
module tb_id_bypass_stage;

    localparam int DATA_W  = 32;
    localparam int NUM_FWD = 3;

    logic                      clk;
    logic                      rst;
    logic                      if_valid_in;
    logic [31:0]               if_PC_in;
    logic [31:0]               if_NNPC_in;
    logic [31:0]               if_Instruct_in;
    logic                      rd1_en_in;
    logic                      rd2_en_in;
    logic [DATA_W-1:0]         rf_RD1_in;
    logic [DATA_W-1:0]         rf_RD2_in;
    logic [NUM_FWD-1:0]        fwd_valid_in;
    logic [NUM_FWD-1:0]        fwd_rdy_in;
    logic [5*NUM_FWD-1:0]      fwd_wnum_in;
    logic [DATA_W*NUM_FWD-1:0] fwd_data_in;
    logic                      exe_allowin_in;
    logic                      flush_in;

    logic                      id_allowin_out;
    logic [4:0]                id_RR1_out;
    logic [4:0]                id_RR2_out;
    logic                      id_valid_out;
    logic [31:0]               id_PC_out;
    logic [31:0]               id_NNPC_out;
    logic [31:0]               id_Instruct_out;
    logic [DATA_W-1:0]         id_RD1_out;
    logic [DATA_W-1:0]         id_RD2_out;
    logic [15:0]               id_stall_cnt_out;

    logic                      s_allowin;
    logic [4:0]                s_rr1;
    logic [4:0]                s_rr2;
    logic                      s_valid;
    logic [31:0]               s_pc;
    logic [31:0]               s_nnpc;
    logic [31:0]               s_instr;
    logic [DATA_W-1:0]         s_rd1;
    logic [DATA_W-1:0]         s_rd2;
    logic [1:0]                s_cnt;

    int total = 0;
    int bad   = 0;

    id_bypass_stage dut (
        .clk(clk), .rst(rst), .if_valid_in(if_valid_in), .id_allowin_out(id_allowin_out),
        .if_PC_in(if_PC_in), .if_NNPC_in(if_NNPC_in), .if_Instruct_in(if_Instruct_in),
        .rd1_en_in(rd1_en_in), .rd2_en_in(rd2_en_in),
        .id_RR1_out(id_RR1_out), .id_RR2_out(id_RR2_out),
        .rf_RD1_in(rf_RD1_in), .rf_RD2_in(rf_RD2_in),
        .fwd_valid_in(fwd_valid_in), .fwd_rdy_in(fwd_rdy_in),
        .fwd_wnum_in(fwd_wnum_in), .fwd_data_in(fwd_data_in),
        .exe_allowin_in(exe_allowin_in), .flush_in(flush_in),
        .id_valid_out(id_valid_out), .id_PC_out(id_PC_out), .id_NNPC_out(id_NNPC_out),
        .id_Instruct_out(id_Instruct_out), .id_RD1_out(id_RD1_out), .id_RD2_out(id_RD2_out),
        .id_stall_cnt_out(id_stall_cnt_out)
    );

    id_bypass_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .if_valid_in(if_valid_in), .id_allowin_out(s_allowin),
        .if_PC_in(if_PC_in), .if_NNPC_in(if_NNPC_in), .if_Instruct_in(if_Instruct_in),
        .rd1_en_in(rd1_en_in), .rd2_en_in(rd2_en_in),
        .id_RR1_out(s_rr1), .id_RR2_out(s_rr2),
        .rf_RD1_in(rf_RD1_in), .rf_RD2_in(rf_RD2_in),
        .fwd_valid_in(fwd_valid_in), .fwd_rdy_in(fwd_rdy_in),
        .fwd_wnum_in(fwd_wnum_in), .fwd_data_in(fwd_data_in),
        .exe_allowin_in(exe_allowin_in), .flush_in(flush_in),
        .id_valid_out(s_valid), .id_PC_out(s_pc), .id_NNPC_out(s_nnpc),
        .id_Instruct_out(s_instr), .id_RD1_out(s_rd1), .id_RD2_out(s_rd2),
        .id_stall_cnt_out(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'd0, rs, rt, 16'h0abc};
    endfunction

    task automatic set_src(input int i, input logic v, input logic r,
                           input logic [4:0] w, input logic [DATA_W-1:0] d);
        fwd_valid_in[i]              = v;
        fwd_rdy_in[i]                = r;
        fwd_wnum_in[i*5 +: 5]        = w;
        fwd_data_in[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_src();
        fwd_valid_in = '0;
        fwd_rdy_in   = '1;
        fwd_wnum_in  = '0;
        fwd_data_in  = '0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (id_valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", id_valid_out); end
        total++; if (id_PC_out !== 32'hBFC00000) begin bad++; $display("FAIL rst_pc: got %h want bfc00000", id_PC_out); end
        total++; if (id_NNPC_out !== 32'hBFC00008) begin bad++; $display("FAIL rst_nnpc: got %h want bfc00008", id_NNPC_out); end
        total++; if (id_Instruct_out !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", id_Instruct_out); end
        total++; if (id_stall_cnt_out !== 16'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", id_stall_cnt_out); end
        total++; if (id_allowin_out !== 1'b1) begin bad++; $display("FAIL rst_allowin: got %0b want 1", id_allowin_out); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_plain();
        @(negedge clk);
        if_valid_in = 1'b1; if_PC_in = 32'hBFC00010; if_NNPC_in = 32'hBFC00018;
        if_Instruct_in = mk(5'd3, 5'd4); rf_RD1_in = 32'h1234; rf_RD2_in = 32'h5678;
        @(posedge clk); #1;
        if_valid_in = 1'b0;
        total++; if (id_valid_out !== 1'b1) begin bad++; $display("FAIL plain_valid: got %0b want 1", id_valid_out); end
        total++; if (id_PC_out !== 32'hBFC00010) begin bad++; $display("FAIL plain_pc: got %h want bfc00010", id_PC_out); end
        total++; if (id_NNPC_out !== 32'hBFC00018) begin bad++; $display("FAIL plain_nnpc: got %h want bfc00018", id_NNPC_out); end
        total++; if (id_RR1_out !== 5'd3 || id_RR2_out !== 5'd4) begin bad++; $display("FAIL plain_rr: got %0d/%0d want 3/4", id_RR1_out, id_RR2_out); end
        total++; if (id_RD1_out !== 32'h1234) begin bad++; $display("FAIL plain_rd1: got %h want 1234", id_RD1_out); end
        total++; if (id_RD2_out !== 32'h5678) begin bad++; $display("FAIL plain_rd2: got %h want 5678", id_RD2_out); end
        total++; if (id_stall_cnt_out !== 16'd0) begin bad++; $display("FAIL plain_cnt: got %0d want 0", id_stall_cnt_out); end
        @(posedge clk); #1;
        total++; if (id_valid_out !== 1'b0) begin bad++; $display("FAIL plain_drain: got %0b want 0", id_valid_out); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        exe_allowin_in = 1'b0; if_valid_in = 1'b1;
        if_PC_in = 32'hBFC00014; if_NNPC_in = 32'hBFC0001C; if_Instruct_in = mk(5'd5, 5'd0);
        @(posedge clk); #1;
        if_valid_in = 1'b0;
        @(negedge clk);
        set_src(0, 1'b1, 1'b1, 5'd5, 32'h11);
        set_src(2, 1'b1, 1'b1, 5'd5, 32'h33);
        #1;
        total++; if (id_RD1_out !== 32'h11) begin bad++; $display("FAIL prio_young: got %h want 11", id_RD1_out); end
        total++; if (id_RD2_out !== 32'h0) begin bad++; $display("FAIL prio_rt_zero: got %h want 0", id_RD2_out); end
        fwd_valid_in[0] = 1'b0;
        #1;
        total++; if (id_RD1_out !== 32'h33) begin bad++; $display("FAIL prio_old: got %h want 33", id_RD1_out); end
        fwd_valid_in[0] = 1'b1; fwd_rdy_in[2] = 1'b0;
        #1;
        total++; if (id_valid_out !== 1'b1) begin bad++; $display("FAIL prio_old_notrdy: got %0b want 1", id_valid_out); end
        fwd_rdy_in[0] = 1'b0; fwd_rdy_in[2] = 1'b1;
        #1;
        total++; if (id_valid_out !== 1'b0 || id_allowin_out !== 1'b0) begin bad++; $display("FAIL prio_young_notrdy: got v=%0b a=%0b want 0/0", id_valid_out, id_allowin_out); end
        clear_src();
        exe_allowin_in = 1'b1;
        @(posedge clk); #1;
        total++; if (id_valid_out !== 1'b0 || id_stall_cnt_out !== 16'd0) begin bad++; $display("FAIL prio_drain: got v=%0b c=%0d want 0/0", id_valid_out, id_stall_cnt_out); end
    endtask

    task automatic test_zero();
        @(negedge clk);
        if_valid_in = 1'b1; if_PC_in = 32'hBFC00018; if_NNPC_in = 32'hBFC00020;
        if_Instruct_in = mk(5'd0, 5'd4); rf_RD1_in = 32'h1234;
        set_src(1, 1'b1, 1'b0, 5'd0, 32'hDEAD);
        @(posedge clk); #1;
        if_valid_in = 1'b0;
        total++; if (id_RD1_out !== 32'h0) begin bad++; $display("FAIL zero_rd1: got %h want 0", id_RD1_out); end
        total++; if (id_valid_out !== 1'b1 || id_allowin_out !== 1'b1) begin bad++; $display("FAIL zero_nostall: got v=%0b a=%0b want 1/1", id_valid_out, id_allowin_out); end
        clear_src();
        @(posedge clk); #1;
        total++; if (id_stall_cnt_out !== 16'd0) begin bad++; $display("FAIL zero_cnt: got %0d want 0", id_stall_cnt_out); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        if_valid_in = 1'b1; if_PC_in = 32'hBFC00020; if_NNPC_in = 32'hBFC00028;
        if_Instruct_in = mk(5'd1, 5'd8); rf_RD2_in = 32'h5678;
        set_src(0, 1'b1, 1'b0, 5'd8, 32'hCAFE);
        @(posedge clk); #1;
        if_PC_in = 32'hBFC00030; if_NNPC_in = 32'hBFC00038; if_Instruct_in = mk(5'd2, 5'd3);
        total++; if (id_valid_out !== 1'b0 || id_allowin_out !== 1'b0) begin bad++; $display("FAIL lu_stall: got v=%0b a=%0b want 0/0", id_valid_out, id_allowin_out); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (id_stall_cnt_out !== 16'd3) begin bad++; $display("FAIL lu_cnt: got %0d want 3", id_stall_cnt_out); end
        total++; if (id_PC_out !== 32'hBFC00020 || id_Instruct_out !== mk(5'd1, 5'd8)) begin bad++; $display("FAIL lu_hold: got %h/%h want bfc00020", id_PC_out, id_Instruct_out); end
        total++; if (id_valid_out !== 1'b0 || id_allowin_out !== 1'b0) begin bad++; $display("FAIL lu_stall3: got v=%0b a=%0b want 0/0", id_valid_out, id_allowin_out); end
        fwd_rdy_in[0] = 1'b1;
        #1;
        total++; if (id_valid_out !== 1'b1 || id_allowin_out !== 1'b1) begin bad++; $display("FAIL lu_release: got v=%0b a=%0b want 1/1", id_valid_out, id_allowin_out); end
        total++; if (id_RD2_out !== 32'hCAFE) begin bad++; $display("FAIL lu_rd2: got %h want cafe", id_RD2_out); end
        @(posedge clk); #1;
        if_valid_in = 1'b0;
        total++; if (id_PC_out !== 32'hBFC00030 || id_valid_out !== 1'b1) begin bad++; $display("FAIL lu_next: got pc=%h v=%0b want bfc00030/1", id_PC_out, id_valid_out); end
        total++; if (id_stall_cnt_out !== 16'd3) begin bad++; $display("FAIL lu_cnt_hold: got %0d want 3", id_stall_cnt_out); end
        clear_src();
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        @(negedge clk);
        if_valid_in = 1'b1; if_PC_in = 32'hBFC00050; if_NNPC_in = 32'hBFC00058;
        if_Instruct_in = mk(5'd0, 5'd9);
        set_src(0, 1'b1, 1'b0, 5'd9, 32'hBEEF);
        @(posedge clk); #1;
        if_PC_in = 32'hBFC00060; if_NNPC_in = 32'hBFC00068; if_Instruct_in = mk(5'd7, 5'd7);
        flush_in = 1'b1;
        #1;
        total++; if (id_valid_out !== 1'b0 || id_allowin_out !== 1'b1) begin bad++; $display("FAIL flush_same: got v=%0b a=%0b want 0/1", id_valid_out, id_allowin_out); end
        @(posedge clk); #1;
        flush_in = 1'b0; if_valid_in = 1'b0;
        #1;
        total++; if (id_allowin_out !== 1'b1 || id_valid_out !== 1'b0) begin bad++; $display("FAIL flush_killed: got a=%0b v=%0b want 1/0", id_allowin_out, id_valid_out); end
        total++; if (id_PC_out !== 32'hBFC00050) begin bad++; $display("FAIL flush_noload: got %h want bfc00050", id_PC_out); end
        total++; if (id_stall_cnt_out !== 16'd3) begin bad++; $display("FAIL flush_cnt: got %0d want 3", id_stall_cnt_out); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        if_valid_in = 1'b1; if_PC_in = 32'hBFC00070; if_NNPC_in = 32'hBFC00078;
        if_Instruct_in = mk(5'd0, 5'd9);
        @(posedge clk); #1;
        if_valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (id_stall_cnt_out !== 16'd8) begin bad++; $display("FAIL sat_wide: got %0d want 8", id_stall_cnt_out); end
        total++; if (s_cnt !== 2'd3) begin bad++; $display("FAIL sat_hold: got %0d want 3", s_cnt); end
        total++; if (id_PC_out !== 32'hBFC00070 || id_valid_out !== 1'b0) begin bad++; $display("FAIL ar_stalled: got pc=%h v=%0b want bfc00070/0", id_PC_out, id_valid_out); end
        #1 rst = 1'b1;
        #1;
        total++; if (id_valid_out !== 1'b0 || id_allowin_out !== 1'b1) begin bad++; $display("FAIL ar_valid: got v=%0b a=%0b want 0/1", id_valid_out, id_allowin_out); end
        total++; if (id_PC_out !== 32'hBFC00000 || id_NNPC_out !== 32'hBFC00008) begin bad++; $display("FAIL ar_pc: got %h/%h want bfc00000/bfc00008", id_PC_out, id_NNPC_out); end
        total++; if (id_Instruct_out !== 32'h0) begin bad++; $display("FAIL ar_instr: got %h want 0", id_Instruct_out); end
        total++; if (id_stall_cnt_out !== 16'd0 || s_cnt !== 2'd0) begin bad++; $display("FAIL ar_cnt: got %0d/%0d want 0/0", id_stall_cnt_out, s_cnt); end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        total++; if (id_valid_out !== 1'b0 || id_allowin_out !== 1'b1 || id_stall_cnt_out !== 16'd0) begin bad++; $display("FAIL ar_after: got v=%0b a=%0b c=%0d want 0/1/0", id_valid_out, id_allowin_out, id_stall_cnt_out); end
        clear_src();
    endtask

    initial begin
        rst = 1'b1;
        if_valid_in = 1'b0; if_PC_in = '0; if_NNPC_in = '0; if_Instruct_in = '0;
        rd1_en_in = 1'b1; rd2_en_in = 1'b1;
        rf_RD1_in = '0; rf_RD2_in = '0;
        exe_allowin_in = 1'b1; flush_in = 1'b0;
        clear_src();
        test_reset();
        test_plain();
        test_priority();
        test_zero();
        test_load_use();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
